// File: rtl/jt12_kon_seq.sv
// Key-on sequencer: per-slot key state from register 0x28 plus CSM auto
// key-on, emitted as a slot-ordered keyon_I stream for the envelope generator.
module jt12_kon_seq #(
    parameter int num_ch = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       kon_we,
    input  logic [2:0] kon_ch,
    input  logic [3:0] kon_op,
    output logic       kon_ready,
    input  logic       csm_en,
    input  logic       tima_ovf,
    output logic [4:0] slot,
    output logic       zero,
    output logic       keyon_I
);

    localparam int NS = 4 * num_ch;
    localparam logic [4:0] LAST = 5'(NS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE
    } csm_t;

    csm_t          st_q, st_d;
    logic          pend_q, pend_d;
    logic [4:0]    slot_q, slot_d;
    logic          zero_q, zero_d;
    logic          keyon_q, keyon_d;
    logic [NS-1:0] kon_reg_q, kon_reg_d;
    logic          buf_v_q, buf_v_d;
    logic          buf_inv_q, buf_inv_d;
    logic [2:0]    buf_ch_q, buf_ch_d;
    logic [3:0]    buf_op_q, buf_op_d;

    logic          accept, apply, wrap, ovf;
    logic [2:0]    wr_ch;
    logic          wr_inv;
    logic [NS-1:0] ch_mask, op_rep, csm_mask, look;

    assign kon_ready = ~buf_v_q;
    assign slot      = slot_q;
    assign zero      = zero_q;
    assign keyon_I   = keyon_q;

    assign accept = kon_we & ~buf_v_q;
    assign apply  = clk_en & buf_v_q;
    assign wrap   = clk_en & (slot_q == LAST);
    assign ovf    = tima_ovf & csm_en;

    assign wr_ch  = kon_ch[2] ? 3'd3 + {1'b0, kon_ch[1:0]}
                              : {1'b0, kon_ch[1:0]};
    assign wr_inv = (kon_ch[1:0] == 2'd3) | (kon_ch[2] & (num_ch == 3));

    assign op_rep = {{num_ch{buf_op_q[3]}}, {num_ch{buf_op_q[2]}},
                     {num_ch{buf_op_q[1]}}, {num_ch{buf_op_q[0]}}};

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            ch_mask[i]  = (3'(i % num_ch) == buf_ch_q);
            csm_mask[i] = ((i % num_ch) == 2);
        end
    end

    always_comb begin
        buf_v_d   = buf_v_q;
        buf_inv_d = buf_inv_q;
        buf_ch_d  = buf_ch_q;
        buf_op_d  = buf_op_q;
        kon_reg_d = kon_reg_q;
        if (apply) begin
            buf_v_d = 1'b0;
            if (!buf_inv_q)
                kon_reg_d = (kon_reg_q & ~ch_mask) | (op_rep & ch_mask);
        end else if (accept) begin
            buf_v_d   = 1'b1;
            buf_inv_d = wr_inv;
            buf_ch_d  = wr_ch;
            buf_op_d  = kon_op;
        end
    end

    always_comb begin
        st_d   = st_q;
        pend_d = pend_q;
        unique case (st_q)
            IDLE:  if (ovf) st_d = ARMED;
            ARMED: if (wrap) st_d = ACTIVE;
            ACTIVE: begin
                if (ovf) pend_d = 1'b1;
                if (wrap) begin
                    st_d   = pend_d ? ARMED : IDLE;
                    pend_d = 1'b0;
                end
            end
            default: st_d = IDLE;
        endcase
        if (!csm_en) begin
            st_d   = IDLE;
            pend_d = 1'b0;
        end
    end

    // The lookup uses next-state key bits so a write landing now is seen.
    always_comb begin
        slot_d  = slot_q;
        zero_d  = zero_q;
        keyon_d = keyon_q;
        look    = '0;
        if (clk_en) begin
            slot_d  = (slot_q == LAST) ? 5'd0 : slot_q + 5'd1;
            zero_d  = (slot_d == 5'd0);
            look    = (kon_reg_d | ((st_d == ACTIVE) ? csm_mask : '0))
                      >> slot_d;
            keyon_d = look[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q      <= IDLE;
            pend_q    <= 1'b0;
            slot_q    <= 5'd0;
            zero_q    <= 1'b1;
            keyon_q   <= 1'b0;
            kon_reg_q <= '0;
            buf_v_q   <= 1'b0;
            buf_inv_q <= 1'b0;
            buf_ch_q  <= 3'd0;
            buf_op_q  <= 4'd0;
        end else begin
            st_q      <= st_d;
            pend_q    <= pend_d;
            slot_q    <= slot_d;
            zero_q    <= zero_d;
            keyon_q   <= keyon_d;
            kon_reg_q <= kon_reg_d;
            buf_v_q   <= buf_v_d;
            buf_inv_q <= buf_inv_d;
            buf_ch_q  <= buf_ch_d;
            buf_op_q  <= buf_op_d;
        end
    end

endmodule

// File: tb/tb_jt12_kon_seq.sv
// Bench for jt12_kon_seq: reset table, directed corner sequences and
// randomized traffic against a round-counting reference model.
module tb_jt12_kon_seq;

    localparam int NUM = 6;
    localparam int NS  = 4 * NUM;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_en = 1'b0;
    logic       kon_we = 1'b0;
    logic [2:0] kon_ch = 3'd0;
    logic [3:0] kon_op = 4'd0;
    logic       kon_ready;
    logic       csm_en = 1'b0;
    logic       tima_ovf = 1'b0;
    logic [4:0] slot;
    logic       zero;
    logic       keyon_I;

    int n_tests = 0;
    int n_fail  = 0;

    jt12_kon_seq #(.num_ch(NUM)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .kon_we(kon_we), .kon_ch(kon_ch), .kon_op(kon_op),
        .kon_ready(kon_ready), .csm_en(csm_en), .tima_ovf(tima_ovf),
        .slot(slot), .zero(zero), .keyon_I(keyon_I)
    );

    always #5 clk = ~clk;

    // Reference model: key bits per slot, counted-down CSM round.
    int       m_slot;
    bit       m_zero, m_key, m_bv, m_binv, m_acc;
    int       m_bch;
    bit [3:0] m_bop;
    bit       m_kon[NS];
    bit       m_armed, m_again;
    int       m_left;

    function automatic void model_reset();
        m_slot = 0; m_zero = 1; m_key = 0;
        m_bv = 0; m_binv = 0; m_bch = 0; m_bop = 0; m_acc = 0;
        for (int i = 0; i < NS; i++) m_kon[i] = 0;
        m_armed = 0; m_again = 0; m_left = 0;
    endfunction

    function automatic void model_edge();
        bit acc, ovf;
        acc = kon_we && !m_bv;
        ovf = tima_ovf && csm_en;
        if (clk_en && m_bv) begin
            if (!m_binv)
                for (int k = 0; k < 4; k++) m_kon[k*NUM + m_bch] = m_bop[k];
            m_bv = 0;
        end
        if (acc) begin
            m_bv   = 1;
            m_bch  = kon_ch[2] * 3 + kon_ch[1:0];
            m_binv = (kon_ch[1:0] == 2'd3) || (kon_ch[2] && NUM == 3);
            m_bop  = kon_op;
        end
        m_acc = acc;
        if (!csm_en) begin
            m_armed = 0; m_again = 0; m_left = 0;
        end else if (m_left > 0) begin
            if (ovf) m_again = 1;
            if (clk_en) begin
                m_left--;
                if (m_left == 0) begin
                    m_armed = m_again;
                    m_again = 0;
                end
            end
        end else if (m_armed) begin
            if (clk_en && m_slot == NS - 1) begin
                m_armed = 0;
                m_left  = NS;
            end
        end else if (ovf) begin
            m_armed = 1;
        end
        if (clk_en) begin
            m_slot = (m_slot + 1) % NS;
            m_zero = (m_slot == 0);
            m_key  = m_kon[m_slot] || (m_left > 0 && m_slot % NUM == 2);
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("slot", int'(slot), m_slot);
        chk("zero", int'(zero), int'(m_zero));
        chk("keyon_I", int'(keyon_I), int'(m_key));
        chk("kon_ready", int'(kon_ready), int'(!m_bv));
    endtask

    task automatic tick(input bit en, input bit we, input bit [2:0] ch,
                        input bit [3:0] op, input bit ovf);
        @(negedge clk);
        clk_en = en; kon_we = we; kon_ch = ch; kon_op = op; tima_ovf = ovf;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic do_write(input bit [2:0] ch, input bit [3:0] op);
        int n;
        n = 0;
        do begin
            tick(1'($urandom_range(0, 1)), 1'b1, ch, op, 1'b0);
            n++;
        end while (!m_acc && n < 60);
        if (!m_acc) begin
            n_tests++; n_fail++;
            $display("FAIL write_timeout: kon_ready=%0d expected accept", kon_ready);
        end
    endtask

    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    endtask

    task automatic run_to_slot(input int s);
        int n;
        n = 0;
        while (m_slot != s && n < 2 * NS) begin
            tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
            n++;
        end
    endtask

    // Three rounds from a CSM pulse: quiet, forced ch2, quiet (kon_reg clear).
    task automatic csm_rounds(input bit twice);
        int r;
        run_to_slot(10);
        tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b1);
        run_en(3);
        if (twice) tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b1);
        r = 0;
        for (int i = 0; i < 3 * NS; i++) begin
            tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
            if (m_slot == 0) r++;
            if (r < 3)
                chk("csm_round", int'(keyon_I),
                    int'(r == 1 && (m_slot % NUM) == 2));
        end
    endtask

    typedef struct {
        bit en;
        int exp_slot;
        bit exp_zero;
        bit exp_key;
    } vec_t;

    vec_t vecs[30];

    initial begin
        for (int i = 0; i < 30; i++) begin
            vecs[i].en       = 1'b1;
            vecs[i].exp_slot = (i + 1) % NS;
            vecs[i].exp_zero = ((i + 1) % NS) == 0;
            vecs[i].exp_key  = 1'b0;
        end

        model_reset();
        #12;
        chk("rst_slot", int'(slot), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_keyon", int'(keyon_I), 0);
        chk("rst_ready", int'(kon_ready), 1);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            tick(vecs[i].en, 1'b0, 3'd0, 4'd0, 1'b0);
            chk("tbl_slot", int'(slot), vecs[i].exp_slot);
            chk("tbl_zero", int'(zero), int'(vecs[i].exp_zero));
            chk("tbl_keyon", int'(keyon_I), int'(vecs[i].exp_key));
        end

        tick(1'b0, 1'b1, 3'b101, 4'b1001, 1'b0);
        chk("ready_drop", int'(kon_ready), 0);
        run_en(NS);
        for (int i = 0; i < NS; i++) begin
            tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
            chk("ch4_round", int'(keyon_I), int'(m_slot == 4 || m_slot == 22));
        end
        do_write(3'b101, 4'b0000);
        run_en(NS);
        for (int i = 0; i < NS; i++) begin
            tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
            chk("ch4_clear", int'(keyon_I), 0);
        end

        do_write(3'b000, 4'b0110);
        run_en(NS);
        tick(1'b0, 1'b1, 3'b011, 4'b1111, 1'b0);
        chk("inv_ready_low", int'(kon_ready), 0);
        tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        chk("inv_ready_back", int'(kon_ready), 1);
        for (int i = 0; i < NS; i++) begin
            tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
            chk("inv_round", int'(keyon_I), int'(m_slot == 6 || m_slot == 12));
        end

        do_write(3'b001, 4'b1111);
        do_write(3'b001, 4'b0010);
        run_en(NS);
        for (int i = 0; i < NS; i++) begin
            tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
            chk("b2b_round", int'(keyon_I),
                int'(m_slot == 6 || m_slot == 12 || m_slot == 7));
        end

        do_write(3'b000, 4'b0000);
        do_write(3'b001, 4'b0000);
        run_en(NS);
        csm_en = 1'b1;
        csm_rounds(1'b0);
        csm_rounds(1'b1);

        do_write(3'b000, 4'b1111);
        run_to_slot(10);
        tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b1);
        run_to_slot(0);
        run_en(5);
        #2 rst = 1'b0;
        clk_en = 1'b0; kon_we = 1'b0; tima_ovf = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_slot", int'(slot), 0);
        chk("mid_rst_zero", int'(zero), 1);
        chk("mid_rst_keyon", int'(keyon_I), 0);
        chk("mid_rst_ready", int'(kon_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NS; i++) begin
            tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
            chk("post_rst", int'(keyon_I), 0);
        end

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) csm_en = ~csm_en;
            tick(1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 5) == 0),
                 3'($urandom), 4'($urandom),
                 1'($urandom_range(0, 40) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jt12_kon_seq.md
# jt12_kon_seq

Key-on sequencer feeding the envelope generator. It holds the per-slot key-on state written through register 0x28 and the CSM (timer A) auto key-on. It produces the time-multiplexed `keyon_I` bit in slot order, together with the slot counter and the `zero` round marker consumed by the envelope generator and its envelope counter. A one-deep write buffer with a ready/valid handshake decouples the CPU-side register write from the `clk_en`-paced slot sequencer.

## Interface
- `num_ch`, default 6, number of channels; 6 or 3 only; slots per round = 4*num_ch.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset; asynchronous and active-low (clears all state while low).
- `clk_en`  in  1  slot advance enable; one slot per `clk_en` cycle.
- `kon_we`  in  1  key-on write valid.
- `kon_ch`  in  3  channel field of 0x28: [2] bank, [1:0] channel in bank.
- `kon_op`  in  4  operator key bits: [0]=S1, [1]=S2, [2]=S3, [3]=S4.
- `kon_ready`  out  1  write buffer empty; write accepted when `kon_we & kon_ready`.
- `csm_en`  in  1  CSM mode enable (channel 3 auto key-on).
- `tima_ovf`  in  1  timer A overflow pulse, one `clk` wide, sampled every `clk`.
- `slot`  out  5  current slot index, 0..4*num_ch-1.
- `zero`  out  1  high while `slot`==0.
- `keyon_I`  out  1  key-on level for the current slot.

## Operation
- Slot mapping: ch_idx = kon_ch[2]*3 + kon_ch[1:0]; slot = op*num_ch + ch_idx, with op 0..3 = S1..S4.
- Invalid channel: kon_ch[1:0]==3, or kon_ch[2]==1 when num_ch==3. The write is accepted, then discarded with no state change.
- Write buffer: an accepted write latches {ch_idx, op mask, valid} and drops `kon_ready` on the next `clk`. On the next `clk_en` cycle the four slot bits of that channel are overwritten with `kon_op`, whether set or clear, and the buffer empties. `kon_ready` returns high on the following `clk`.
- While `kon_ready`=0 the writer holds `kon_we`/data. A `kon_we` seen while not ready is ignored.
- Key state: `kon_reg[4*num_ch-1:0]` register bits.
- CSM state machine, states IDLE, ARMED, ACTIVE:
  - IDLE -> ARMED on `tima_ovf & csm_en`.
  - ARMED -> ACTIVE on the `clk_en` cycle where slot wraps to 0.
  - ACTIVE lasts exactly one round (4*num_ch `clk_en` cycles), then goes to IDLE. If another overflow was latched during ACTIVE, it goes to ARMED instead; further overflows in the same round collapse into one.
  - Clearing `csm_en` forces IDLE on the next `clk`.
- CSM forcing: during ACTIVE, slots with ch_idx==2 (all four ops) read as keyed on.
- Output: keyon_I = kon_reg[slot] | (ACTIVE & ch_idx(slot)==2).
- Slot counter increments on `clk_en` and wraps from 4*num_ch-1 to 0.

## Timing
- Reset values: slot=0, zero=1, keyon_I=0, kon_ready=1, kon_reg=0, CSM=IDLE, buffer empty.
- All outputs are registered; `slot`, `zero` and `keyon_I` change only on `clk_en` cycles.
- `keyon_I` for slot s is valid in the same cycles that `slot`==s.
- Write-to-effect latency: a write accepted at edge t updates `kon_reg` at the first `clk_en` edge after t. That slot's `keyon_I` reflects it the next time `slot` reaches it.
- Simultaneous write and buffer drain in the same edge is not possible: ready is low while the buffer is full.
- A write lands on its `clk_en` edge before the `keyon_I` lookup for the new slot. A write targeting the slot entered at that edge is therefore visible immediately.
- Reset asserted mid-round clears pending writes, CSM and the counter asynchronously. After release, the sequence restarts at slot 0.
- `tima_ovf` coinciding with the wrap edge in IDLE goes to ARMED; ACTIVE starts one round later.

## Test plan
- Reset, then 30 `clk_en` pulses: `slot` runs 0..23,0..5; `zero`=1 only at slot 0; `keyon_I`=0 throughout.
- Write kon_ch=3'b101, kon_op=4'b1001 (ch_idx 4): after apply, `keyon_I`=1 only at slots 4 and 22. Then write kon_op=0: all 0 from the next round on.
- Write with kon_ch[1:0]=3: `kon_ready` pulses low for one apply, and `keyon_I` is unchanged for every slot.
- Back-to-back writes with `kon_we` held high: second write waits until `kon_ready`=1, and both take effect in order.
- csm_en=1, `tima_ovf` pulse mid-round: next round has `keyon_I`=1 at slots 2, 8, 14, 20 only; the round after returns to `kon_reg` values. Two pulses in one round give a single extra ACTIVE round.
- Assert `rst` low during ACTIVE with kon_reg non-zero: outputs return to reset values immediately. After release, `keyon_I`=0 for all slots.
